// File: rtl/synth_pkg.sv
// Shared definitions for the synth envelope stage.
// Contents: bus width constants, envelope register offsets relative to the
// envelope base address, and the envelope state encoding.
package synth_pkg;

  localparam int BUS_ADDR_W = 16;
  localparam int BUS_DATA_W = 8;

  localparam logic [2:0] ENV_ATTACK  = 3'd0;
  localparam logic [2:0] ENV_DECAY   = 3'd1;
  localparam logic [2:0] ENV_SUSTAIN = 3'd2;
  localparam logic [2:0] ENV_RELEASE = 3'd3;
  localparam logic [2:0] ENV_STATUS  = 3'd4;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ATTACK  = 3'd1,
    DECAY   = 3'd2,
    SUSTAIN = 3'd3,
    RELEASE = 3'd4
  } env_state_t;

endpackage

// File: rtl/envelope_bus_regs.sv
// Envelope register block on the synth bus.
// Synchronises the bus strobe into the clock domain, decodes writes to the
// four envelope registers (attack, decay, sustain, release) and, when the
// ENVELOPE_READBACK_EN macro is defined, drives register/status readback.
// Ports:
//   clock, reset          system clock, async active-low reset
//   bus_address/bus_data  synth bus address and bidirectional data
//   bus_read_write        1 = write, 0 = read
//   bus_clock             bus strobe, asynchronous to clock
//   state                 envelope state for status readback (readback build)
//   *_rate, sustain_level register contents
module envelope_bus_regs
  import synth_pkg::*;
#(
  parameter logic [BUS_ADDR_W-1:0] BASE_ADDR = 16'h0014
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [BUS_ADDR_W-1:0] bus_address,
  inout  wire  [BUS_DATA_W-1:0] bus_data,
  input  logic                  bus_read_write,
  input  logic                  bus_clock,
`ifdef ENVELOPE_READBACK_EN
  input  env_state_t            state,
`endif
  output logic [BUS_DATA_W-1:0] attack_rate,
  output logic [BUS_DATA_W-1:0] decay_rate,
  output logic [BUS_DATA_W-1:0] sustain_level,
  output logic [BUS_DATA_W-1:0] release_rate
);

  // [0],[1] form the synchroniser, [2] holds the previous synchronised value.
  logic [2:0] sync_q;
  logic       strobe_rise;
  logic [BUS_ADDR_W-1:0] offset;
  logic       in_range;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) sync_q <= 3'b000;
    else        sync_q <= {sync_q[1:0], bus_clock};
  end

  assign strobe_rise = sync_q[1] & ~sync_q[2];
  // Addresses below the base wrap to large offsets and fall out of range.
  assign offset      = bus_address - BASE_ADDR;
  assign in_range    = offset < 16'd4;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      attack_rate   <= 8'h00;
      decay_rate    <= 8'h00;
      sustain_level <= 8'h80;
      release_rate  <= 8'h00;
    end else if (strobe_rise && bus_read_write && in_range) begin
      case (offset[2:0])
        ENV_ATTACK:  attack_rate   <= bus_data;
        ENV_DECAY:   decay_rate    <= bus_data;
        ENV_SUSTAIN: sustain_level <= bus_data;
        ENV_RELEASE: release_rate  <= bus_data;
        default: ;
      endcase
    end
  end

`ifdef ENVELOPE_READBACK_EN
  logic                  drive_en;
  logic [BUS_DATA_W-1:0] rd_data;
  logic                  strobe_fall;

  assign strobe_fall = ~sync_q[1] & sync_q[2];

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      drive_en <= 1'b0;
      rd_data  <= 8'h00;
    end else if (strobe_fall) begin
      drive_en <= 1'b0;
    end else if (strobe_rise && !bus_read_write && offset <= 16'd4) begin
      drive_en <= 1'b1;
      case (offset[2:0])
        ENV_ATTACK:  rd_data <= attack_rate;
        ENV_DECAY:   rd_data <= decay_rate;
        ENV_SUSTAIN: rd_data <= sustain_level;
        ENV_RELEASE: rd_data <= release_rate;
        ENV_STATUS:  rd_data <= {5'b00000, state};
        default:     rd_data <= 8'h00;
      endcase
    end
  end

  assign bus_data = drive_en ? rd_data : 8'hzz;
`endif

endmodule

// File: rtl/envelope_gen.sv
// ADSR envelope stage following the oscillator.
// Scales the offset-binary oscillator sample by a 16-bit envelope level that
// moves through attack/decay/sustain/release on prescaled ticks.
// Optional macro ENVELOPE_READBACK_EN enables bus readback of the registers
// and of the current state (base + 4).
// Ports:
//   Clock, Reset      system clock, async active-low reset
//   BusAddress        synth bus address
//   BusData           synth bus data (bidirectional, Z unless reading back)
//   BusReadWrite      1 = write, 0 = read
//   BusClock          bus strobe, asynchronous to Clock
//   Gate              note gate, synchronous to Clock
//   Waveform          offset-binary oscillator sample (0x80 = zero)
//   EnvLevel          registered Level[15:8]
//   WaveOut           registered enveloped sample, offset-binary
//
// state   | meaning
// IDLE    | level held at 0
// ATTACK  | level rising by attack step, saturates at 0xFFFF
// DECAY   | level falling by decay step toward sustain level
// SUSTAIN | level tracks {sustain, 8'h00} every tick
// RELEASE | level falling by release step toward 0
module envelope_gen
  import synth_pkg::*;
#(
  parameter logic [BUS_ADDR_W-1:0] BASE_ADDR  = 16'h0014,
  parameter int                    PRESCALE   = 16,
  parameter int                    RATE_SHIFT = 4
) (
  input  logic                  Clock,
  input  logic                  Reset,
  input  logic [BUS_ADDR_W-1:0] BusAddress,
  inout  wire  [BUS_DATA_W-1:0] BusData,
  input  logic                  BusReadWrite,
  input  logic                  BusClock,
  input  logic                  Gate,
  input  logic [7:0]            Waveform,
  output logic [7:0]            EnvLevel,
  output logic [7:0]            WaveOut
);

  logic [7:0]  attack_rate, decay_rate, sustain_level, release_rate;
  env_state_t  state, st_eff, state_nxt;
  logic [15:0] level, level_nxt, step, sustain_word;
  logic [16:0] sum;
  logic [7:0]  rate;
  logic [15:0] presc_cnt;
  logic        tick, gate_q, gate_rise, gate_fall;
  logic signed [8:0]  sample;
  logic signed [17:0] product;

  envelope_bus_regs #(.BASE_ADDR(BASE_ADDR)) u_regs (
    .clock          (Clock),
    .reset          (Reset),
    .bus_address    (BusAddress),
    .bus_data       (BusData),
    .bus_read_write (BusReadWrite),
    .bus_clock      (BusClock),
`ifdef ENVELOPE_READBACK_EN
    .state          (state),
`endif
    .attack_rate    (attack_rate),
    .decay_rate     (decay_rate),
    .sustain_level  (sustain_level),
    .release_rate   (release_rate)
  );

  // Free-running prescaler; not restarted by Gate.
  assign tick = (presc_cnt == 16'(PRESCALE - 1));

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset)    presc_cnt <= 16'h0000;
    else if (tick) presc_cnt <= 16'h0000;
    else           presc_cnt <= presc_cnt + 16'h0001;
  end

  assign gate_rise    = Gate & ~gate_q;
  assign gate_fall    = ~Gate & gate_q;
  assign sustain_word = {sustain_level, 8'h00};
  assign step         = 16'({8'h00, rate} << RATE_SHIFT);
  assign sum          = {1'b0, level} + {1'b0, step};

  // Gate edges act first so a coincident tick runs in the new state.
  always_comb begin
    st_eff = state;
    if (gate_rise)
      st_eff = ATTACK;
    else if (gate_fall && (state == ATTACK || state == DECAY || state == SUSTAIN))
      st_eff = RELEASE;
    case (st_eff)
      ATTACK:  rate = attack_rate;
      DECAY:   rate = decay_rate;
      RELEASE: rate = release_rate;
      default: rate = 8'h00;
    endcase
  end

  // A zero step means the state target is reached on the next tick.
  always_comb begin
    state_nxt = st_eff;
    level_nxt = level;
    if (tick) begin
      case (st_eff)
        IDLE: level_nxt = 16'h0000;
        ATTACK: begin
          if (step == 16'h0000 || sum >= 17'h0FFFF) begin
            level_nxt = 16'hFFFF;
            state_nxt = DECAY;
          end else begin
            level_nxt = sum[15:0];
          end
        end
        DECAY: begin
          if (step == 16'h0000 || level < step || (level - step) <= sustain_word) begin
            level_nxt = sustain_word;
            state_nxt = SUSTAIN;
          end else begin
            level_nxt = level - step;
          end
        end
        SUSTAIN: level_nxt = sustain_word;
        RELEASE: begin
          if (step == 16'h0000 || level <= step) begin
            level_nxt = 16'h0000;
            state_nxt = IDLE;
          end else begin
            level_nxt = level - step;
          end
        end
        default: begin
          level_nxt = 16'h0000;
          state_nxt = IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      state  <= IDLE;
      level  <= 16'h0000;
      gate_q <= 1'b0;
    end else begin
      state  <= state_nxt;
      level  <= level_nxt;
      gate_q <= Gate;
    end
  end

  // Signed sample times unsigned level byte; bits [15:8] of the product are
  // the arithmetic >>> 8 truncated to 8 bits.
  assign sample  = $signed({1'b0, Waveform}) - 9'sd128;
  assign product = sample * $signed({1'b0, level[15:8]});

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      EnvLevel <= 8'h00;
      WaveOut  <= 8'h80;
    end else begin
      EnvLevel <= level[15:8];
      WaveOut  <= 8'h80 + 8'(product >>> 8);
    end
  end

endmodule

// File: tb/tb_envelope_gen.sv
module tb_envelope_gen;

  localparam int PRESCALE   = 1;
  localparam int RATE_SHIFT = 4;
  localparam int S_IDLE = 0, S_ATTACK = 1, S_DECAY = 2, S_SUSTAIN = 3, S_RELEASE = 4;

  logic        Clock = 1'b0;
  logic        Reset = 1'b0;
  logic [15:0] BusAddress = 16'h0000;
  logic        BusReadWrite = 1'b0;
  logic        BusClock = 1'b0;
  logic        Gate = 1'b0;
  logic [7:0]  Waveform = 8'hFF;
  logic [7:0]  EnvLevel, WaveOut;
  wire  [7:0]  BusData;
  logic        tb_drive = 1'b0;
  logic [7:0]  tb_data = 8'h00;

  assign BusData = tb_drive ? tb_data : 8'hzz;

  int n_checks = 0;
  int n_pass = 0;

  // Reference model state
  int         m_regs [4] = '{0, 0, 128, 0};
  int         m_state = 0;
  int         m_level = 0;
  int         m_cyc = 0;
  logic       m_gate = 1'b0;
  logic [7:0] exp_env = 8'h00;
  logic [7:0] exp_wave = 8'h80;

  envelope_gen #(.BASE_ADDR(16'h0014), .PRESCALE(PRESCALE), .RATE_SHIFT(RATE_SHIFT)) dut (
    .Clock(Clock), .Reset(Reset), .BusAddress(BusAddress), .BusData(BusData),
    .BusReadWrite(BusReadWrite), .BusClock(BusClock), .Gate(Gate),
    .Waveform(Waveform), .EnvLevel(EnvLevel), .WaveOut(WaveOut)
  );

  always #5 Clock = ~Clock;

  function automatic logic [7:0] wave_ref(input logic [7:0] w, input int l);
    int s, p;
    s = int'(w) - 128;
    p = s * l;
    return 8'((128 + (p >>> 8)) & 255);
  endfunction

  // Envelope computed in plain integer arithmetic, one update per tick.
  always @(posedge Clock or negedge Reset) begin : model
    int st, lv, stp, sus;
    if (!Reset) begin
      m_state <= S_IDLE; m_level <= 0; m_gate <= 1'b0; m_cyc <= 0;
      exp_env <= 8'h00; exp_wave <= 8'h80;
    end else begin
      exp_env  <= 8'(m_level / 256);
      exp_wave <= wave_ref(Waveform, m_level / 256);
      st = m_state;
      lv = m_level;
      if (Gate && !m_gate) st = S_ATTACK;
      else if (!Gate && m_gate && st >= S_ATTACK && st <= S_SUSTAIN) st = S_RELEASE;
      if (m_cyc % PRESCALE == PRESCALE - 1) begin
        sus = m_regs[2] * 256;
        case (st)
          S_ATTACK: begin
            stp = m_regs[0] * (1 << RATE_SHIFT);
            if (stp == 0 || lv + stp >= 65535) begin lv = 65535; st = S_DECAY; end
            else lv = lv + stp;
          end
          S_DECAY: begin
            stp = m_regs[1] * (1 << RATE_SHIFT);
            if (stp == 0 || lv - stp <= sus) begin lv = sus; st = S_SUSTAIN; end
            else lv = lv - stp;
          end
          S_SUSTAIN: lv = sus;
          S_RELEASE: begin
            stp = m_regs[3] * (1 << RATE_SHIFT);
            if (stp == 0 || lv - stp <= 0) begin lv = 0; st = S_IDLE; end
            else lv = lv - stp;
          end
          default: lv = 0;
        endcase
      end
      m_gate  <= Gate;
      m_cyc   <= m_cyc + 1;
      m_state <= st;
      m_level <= lv;
    end
  end

  task automatic bus_write(input logic [15:0] addr, input logic [7:0] data);
    @(negedge Clock);
    BusAddress = addr; BusReadWrite = 1'b1; tb_data = data; tb_drive = 1'b1;
    repeat (2) @(negedge Clock);
    BusClock = 1'b1;
    repeat (5) @(negedge Clock);
    BusClock = 1'b0;
    repeat (5) @(negedge Clock);
    tb_drive = 1'b0; BusReadWrite = 1'b0;
    if (addr >= 16'h0014 && addr <= 16'h0017) m_regs[addr - 16'h0014] = int'(data);
  endtask

  task automatic bus_strobe_read(input logic [15:0] addr, output logic [7:0] data);
    @(negedge Clock);
    BusAddress = addr; BusReadWrite = 1'b0; tb_drive = 1'b0;
    repeat (2) @(negedge Clock);
    BusClock = 1'b1;
    repeat (5) @(negedge Clock);
    data = BusData;
    BusClock = 1'b0;
    repeat (5) @(negedge Clock);
  endtask

  task automatic test_reset();
    Reset = 1'b0; Waveform = 8'hFF; Gate = 1'b0;
    repeat (10) @(negedge Clock);
    n_checks++;
    if (WaveOut !== 8'h80) $display("FAIL reset_waveout got %h want 80", WaveOut);
    else n_pass++;
    n_checks++;
    if (EnvLevel !== 8'h00) $display("FAIL reset_envlevel got %h want 00", EnvLevel);
    else n_pass++;
    n_checks++;
    if (3'(dut.state) !== 3'(S_IDLE)) $display("FAIL reset_state got %0d want 0", dut.state);
    else n_pass++;
    Reset = 1'b1;
`ifdef ENVELOPE_READBACK_EN
    begin
      logic [7:0] rd;
      bus_strobe_read(16'h0016, rd);
      n_checks++;
      if (rd !== 8'h80) $display("FAIL reset_sustain_read got %h want 80", rd);
      else n_pass++;
    end
`endif
  endtask

  task automatic test_attack_decay();
    int k, peak, sus_cycles;
    bus_write(16'h0014, 8'h10);
    bus_write(16'h0015, 8'h10);
    bus_write(16'h0016, 8'h80);
    @(negedge Clock);
    Gate = 1'b1;
    peak = 0; sus_cycles = 0;
    for (k = 0; k < 700; k++) begin
      @(negedge Clock);
      if (int'(EnvLevel) > peak) peak = int'(EnvLevel);
      n_checks++;
      if ({EnvLevel, WaveOut} !== {exp_env, exp_wave})
        $display("FAIL attack_decay cyc %0d env/wave got %h/%h want %h/%h", k, EnvLevel, WaveOut, exp_env, exp_wave);
      else n_pass++;
      if (m_state == S_SUSTAIN) sus_cycles++;
      if (sus_cycles > 2) break;
    end
    n_checks++;
    if (k >= 700) $display("FAIL attack_decay_timeout got %0d cycles want <700", k);
    else n_pass++;
    n_checks++;
    if (peak !== 255) $display("FAIL attack_peak got %h want ff", peak);
    else n_pass++;
    n_checks++;
    if (EnvLevel !== 8'h80) $display("FAIL sustain_level got %h want 80", EnvLevel);
    else n_pass++;
    n_checks++;
    if (3'(dut.state) !== 3'(S_SUSTAIN)) $display("FAIL sustain_state got %0d want 3", dut.state);
    else n_pass++;
  endtask

  task automatic test_sustain_wave();
    @(negedge Clock);
    Waveform = 8'hFF;
    @(negedge Clock);
    n_checks++;
    if (WaveOut !== 8'hBF) $display("FAIL sustain_wave_ff got %h want bf", WaveOut);
    else n_pass++;
    Waveform = 8'h00;
    @(negedge Clock);
    n_checks++;
    if (WaveOut !== 8'h40) $display("FAIL sustain_wave_00 got %h want 40", WaveOut);
    else n_pass++;
  endtask

  task automatic test_release();
    bus_write(16'h0017, 8'hFF);
    @(negedge Clock);
    Gate = 1'b0;
    for (int k = 0; k < 10; k++) begin
      @(negedge Clock);
      Waveform = 8'($urandom);
      n_checks++;
      if ({EnvLevel, WaveOut} !== {exp_env, exp_wave})
        $display("FAIL release cyc %0d env/wave got %h/%h want %h/%h", k, EnvLevel, WaveOut, exp_env, exp_wave);
      else n_pass++;
    end
    n_checks++;
    if (EnvLevel !== 8'h00) $display("FAIL release_end_level got %h want 00", EnvLevel);
    else n_pass++;
    n_checks++;
    if (3'(dut.state) !== 3'(S_IDLE)) $display("FAIL release_end_state got %0d want 0", dut.state);
    else n_pass++;
    @(negedge Clock);
    n_checks++;
    if (WaveOut !== 8'h80) $display("FAIL release_end_wave got %h want 80", WaveOut);
    else n_pass++;
  endtask

  task automatic test_retrigger();
    int k;
    bus_write(16'h0017, 8'h10);
    @(negedge Clock);
    Gate = 1'b1;
    for (k = 0; k < 700 && m_state != S_SUSTAIN; k++) @(negedge Clock);
    Gate = 1'b0;
    for (k = 0; k < 300 && m_level > 16'h4000; k++) begin
      @(negedge Clock);
      n_checks++;
      if (EnvLevel !== exp_env) $display("FAIL retrig_release cyc %0d got %h want %h", k, EnvLevel, exp_env);
      else n_pass++;
    end
    n_checks++;
    if (k >= 300) $display("FAIL retrig_timeout got %0d cycles want <300", k);
    else n_pass++;
    Gate = 1'b1;
    @(negedge Clock);
    n_checks++;
    if (3'(dut.state) !== 3'(S_ATTACK)) $display("FAIL retrig_state got %0d want 1", dut.state);
    else n_pass++;
    @(negedge Clock);
    n_checks++;
    if (EnvLevel < 8'h40) $display("FAIL retrig_level got %h want >=40", EnvLevel);
    else n_pass++;
    n_checks++;
    if (EnvLevel !== exp_env) $display("FAIL retrig_model got %h want %h", EnvLevel, exp_env);
    else n_pass++;
    Gate = 1'b0;
    for (k = 0; k < 2000 && m_state != S_IDLE; k++) @(negedge Clock);
    repeat (2) @(negedge Clock);
  endtask

  task automatic test_bus_ignore();
    logic [7:0] rd;
    bus_write(16'h0018, 8'h01);
    bus_write(16'h0013, 8'h01);
    bus_strobe_read(16'h0014, rd);
`ifdef ENVELOPE_READBACK_EN
    n_checks++;
    if (rd !== 8'h10) $display("FAIL readback_attack got %h want 10", rd);
    else n_pass++;
    bus_strobe_read(16'h0018, rd);
    n_checks++;
    if (rd !== 8'h00) $display("FAIL readback_status got %h want 00", rd);
    else n_pass++;
`endif
    @(negedge Clock);
    Gate = 1'b1;
    for (int k = 0; k < 60; k++) begin
      @(negedge Clock);
      Waveform = 8'($urandom);
      n_checks++;
      if ({EnvLevel, WaveOut} !== {exp_env, exp_wave})
        $display("FAIL bus_ignore cyc %0d env/wave got %h/%h want %h/%h", k, EnvLevel, WaveOut, exp_env, exp_wave);
      else n_pass++;
    end
    Gate = 1'b0;
    for (int k = 0; k < 3000 && m_state != S_IDLE; k++) @(negedge Clock);
  endtask

  function automatic logic [7:0] rnd_rate();
    int r;
    r = $urandom_range(0, 255);
    if (r < 8) r = 0;
    return 8'(r);
  endfunction

  task automatic test_random();
    int on_len, k;
    for (int it = 0; it < 6; it++) begin
      bus_write(16'h0014, rnd_rate());
      bus_write(16'h0015, rnd_rate());
      bus_write(16'h0016, 8'($urandom));
      bus_write(16'h0017, rnd_rate());
      @(negedge Clock);
      Gate = 1'b1;
      on_len = $urandom_range(20, 500);
      for (k = 0; k < on_len + 3000 && !(k > on_len && m_state == S_IDLE); k++) begin
        @(negedge Clock);
        Waveform = 8'($urandom);
        if (k == on_len / 2 && it[0]) Gate = 1'b0;
        if (k == on_len / 2 + 3 && it[0]) Gate = 1'b1;
        if (k == on_len) Gate = 1'b0;
        n_checks++;
        if ({EnvLevel, WaveOut} !== {exp_env, exp_wave})
          $display("FAIL random it %0d cyc %0d env/wave got %h/%h want %h/%h", it, k, EnvLevel, WaveOut, exp_env, exp_wave);
        else n_pass++;
      end
      n_checks++;
      if (m_state != S_IDLE || 3'(dut.state) !== 3'(S_IDLE))
        $display("FAIL random_idle it %0d got %0d want 0", it, dut.state);
      else n_pass++;
    end
  endtask

  task automatic test_reset_midnote();
    bus_write(16'h0014, 8'h08);
    @(negedge Clock);
    Gate = 1'b1;
    repeat (100) @(negedge Clock);
    Reset = 1'b0;
    m_regs = '{0, 0, 128, 0};
    #1;
    n_checks++;
    if ({EnvLevel, WaveOut} !== 16'h0080)
      $display("FAIL midnote_reset env/wave got %h/%h want 00/80", EnvLevel, WaveOut);
    else n_pass++;
    n_checks++;
    if (3'(dut.state) !== 3'(S_IDLE)) $display("FAIL midnote_state got %0d want 0", dut.state);
    else n_pass++;
    Gate = 1'b0;
    @(negedge Clock);
    Reset = 1'b1;
  endtask

  initial begin
    test_reset();
    test_attack_decay();
    test_sustain_wave();
    test_release();
    test_retrigger();
    test_bus_ignore();
    test_random();
    test_reset_midnote();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
